// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and the conditional negate helper for muldiv_unit
package muldiv_pkg;
  typedef enum logic [1:0] {MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3} md_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} md_state_t;
  localparam logic [1:0] MD_OP_MULT = 2'd0;
  localparam logic [1:0] MD_OP_MULTU = 2'd1;
  localparam logic [1:0] MD_OP_DIV = 2'd2;
  localparam logic [1:0] MD_OP_DIVU = 2'd3;
  localparam int MD_MAX_W = 128;
  function automatic logic [MD_MAX_W-1:0] neg_if(input logic [MD_MAX_W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide owning HI/LO, one result bit per cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  md_state_t state, next_state;
  md_op_t op_r;
  logic [WIDTH-1:0] a_r, b_r, a_raw;
  logic [WIDTH:0] rem, psum, trial;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic neg_q, neg_r, sgn, is_div, fit;
  assign sgn = ~op[0];
  assign is_div = (op_r == DIV) || (op_r == DIVU);
  assign psum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_r[0] ? a_r : '0};
  assign trial = {rem[WIDTH-1:0], a_r[WIDTH-1]};
  assign fit = trial >= {1'b0, b_r};
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // next state: accept in IDLE, iterate WIDTH cycles, one fix-up cycle
  always_comb begin
    next_state = (state == IDLE && start) ? RUN :
                 (state == RUN && count == CNT_W'(WIDTH - 1)) ? FIX :
                 (state == FIX) ? IDLE : state;
  end
  // datapath: operand latch, shift-add / restoring divide, sign fix-up, move-to writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r <= MULT;
      a_r <= '0;
      b_r <= '0;
      a_raw <= '0;
      rem <= '0;
      acc <= '0;
      count <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= next_state != IDLE;
      done <= state == FIX;
      if (state == IDLE && start) begin
        op_r <= md_op_t'(op);
        a_r <= WIDTH'(neg_if(MD_MAX_W'(op_a), sgn & op_a[WIDTH-1]));
        b_r <= WIDTH'(neg_if(MD_MAX_W'(op_b), sgn & op_b[WIDTH-1]));
        a_raw <= op_a;
        neg_q <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        neg_r <= sgn & op_a[WIDTH-1];
        acc <= '0;
        rem <= '0;
        count <= '0;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (state == RUN) begin
        count <= count + CNT_W'(1);
        if (is_div) begin
          rem <= fit ? trial - {1'b0, b_r} : trial;
          a_r <= {a_r[WIDTH-2:0], fit};
        end else begin
          acc <= {psum, acc[WIDTH-1:1]};
          b_r <= b_r >> 1;
        end
      end else if (state == FIX) begin
        if (!is_div) {hi, lo} <= (2*WIDTH)'(neg_if(MD_MAX_W'(acc), neg_q));
        else if (b_r == '0) begin
          lo <= '1;
          hi <= a_raw;
        end else begin
          lo <= WIDTH'(neg_if(MD_MAX_W'(a_r), neg_q));
          hi <= WIDTH'(neg_if(MD_MAX_W'(rem), neg_r));
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus handshake and reset sequences for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'd0;
  logic [31:0] op_a = '0, op_b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[13];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    op_a = a;
    op_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'h80000000, 32'h00000010, 32'h00000000, 32'h08000000};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[7]  = '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[11] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[12] = '{DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    tick();

    wdata = 32'hA5;
    lo_we = 1'b1;
    tick();
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'hA5);
    check("mtlo_done", 64'(done), 64'd0);
    check("mtlo_hi", 64'(hi), 64'd0);
    wdata = 32'h11;
    hi_we = 1'b1;
    lo_we = 1'b1;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mt_both_hi", 64'(hi), 64'h11);
    check("mt_both_lo", 64'(lo), 64'h11);

    issue(MULT, 32'd5, 32'd6);
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (3) tick();
    start = 1'b1;
    op = DIVU;
    op_a = 32'd1;
    op_b = 32'd1;
    hi_we = 1'b1;
    wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    check("mthi_busy_hi", 64'(hi), 64'h11);
    wait_done(5, n);
    check("busy_op_latency", 64'(n), 64'd34);
    check("busy_op_hi", 64'(hi), 64'd0);
    check("busy_op_lo", 64'(lo), 64'd30);

    lo_we = 1'b1;
    wdata = 32'hFF;
    issue(MULTU, 32'd2, 32'd3);
    lo_we = 1'b0;
    check("start_wins_lo", 64'(lo), 64'd30);
    check("done_cycle_start_busy", 64'(busy), 64'd1);
    wait_done(1, n);
    check("b2b_latency", 64'(n), 64'd34);
    check("b2b_lo", 64'(lo), 64'd6);
    check("b2b_hi", 64'(hi), 64'd0);
    tick();
    check("b2b_done_pulse", 64'(done), 64'd0);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
      wait_done(1, n);
      check($sformatf("v%0d_latency", i), 64'(n), 64'd34);
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      tick();
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
    end

    issue(DIV, 32'hFFFFFFF9, 32'd2);
    repeat (9) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    #3 reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_hi", 64'(hi), 64'd0);
    check("async_reset_lo", 64'(lo), 64'd0);
    #1 reset = 1'b0;
    tick();
    check("post_reset_idle", 64'(busy), 64'd0);
    issue(MULT, 32'd5, 32'd6);
    wait_done(1, n);
    check("post_reset_latency", 64'(n), 64'd34);
    check("post_reset_lo", 64'(lo), 64'd30);
    check("post_reset_hi", 64'(hi), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
